inst_fetch_mem: RTL and testbench

Parametrised instruction memory with a valid/ready fetch interface. It replaces the fixed 4096x32 ROM-style memory that is read every cycle. It accepts byte-addressed fetch requests from the fetch stage and returns word data through a response FIFO, with backpressure, misalignment and out-of-range faults, flush, and a word-wide program-load port for bootloading. It sits between the PC/fetch logic and the decode stage.

---
 rtl/inst_mem_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/inst_fetch_mem.sv | 100 ++++++++++
 tb/tb_inst_fetch_mem.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared constants, response entry type and address helpers for the fetch memory
package inst_mem_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int DEPTH_DEFAULT  = 4096;
  localparam int ADDR_MAX_W     = 64;

  typedef struct packed {
    logic                      fault;
    logic [DATA_W_DEFAULT-1:0] data;
  } rsp_entry_t;

  // Byte address to word index; lsb is log2 of the word size in bytes.
  function automatic logic [ADDR_MAX_W-1:0] word_index(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int unsigned lsb);
    return addr >> lsb;
  endfunction

  // A fetch faults when it is not word aligned or falls past the last word.
  function automatic logic is_fault(input logic [ADDR_MAX_W-1:0] addr,
                                    input int unsigned lsb,
                                    input int unsigned depth);
    logic [ADDR_MAX_W-1:0] mask;
    mask = (64'd1 << lsb) - 64'd1;
    return ((addr & mask) != '0) || (word_index(addr, lsb) >= ADDR_MAX_W'(depth));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic synchronous FIFO with count, flags and synchronous clear
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; data needs no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy bookkeeping, emptied by reset or clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_mem.sv
// rtl/inst_fetch_mem.sv - instruction memory with valid/ready fetch, response FIFO, faults, flush and program port
module inst_fetch_mem
  import inst_mem_pkg::*;
#(
  parameter int    DATA_W    = DATA_W_DEFAULT,
  parameter int    DEPTH     = DEPTH_DEFAULT,
  parameter int    ADDR_W    = 32,
  parameter int    RSP_DEPTH = 4,
  parameter string INIT_FILE = "instmem.dat",
  localparam int   IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam int unsigned LSB   = $clog2(DATA_W / 8);
  localparam int          ENT_W = DATA_W + 1;
  localparam int          CNT_W = $clog2(RSP_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic                  s1_valid_q, s1_fault_q;
  logic [DATA_W-1:0]     s1_data_q;
  logic [ADDR_MAX_W-1:0] addr_ext;
  logic                  req_fault;
  logic [IDX_W-1:0]      rd_idx;
  logic                  accept, pop, s1_consumed;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]      fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  head_fault;
  logic [DATA_W-1:0]     head_data;

  assign addr_ext  = ADDR_MAX_W'(req_addr);
  assign req_fault = is_fault(addr_ext, LSB, DEPTH);
  assign rd_idx    = IDX_W'(word_index(addr_ext, LSB));

  // Credits count both the FIFO and the stage-1 slot; rsp_ready is deliberately absent.
  assign req_ready = !reset && !flush &&
                     ((32'(fifo_count) + 32'(s1_valid_q)) < 32'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;

  // Older entries in the FIFO always go out before the stage-1 entry.
  assign {head_fault, head_data} = fifo_empty ? {s1_fault_q, s1_data_q} : fifo_head;
  assign rsp_valid   = !fifo_empty || s1_valid_q;
  assign rsp_data    = rsp_valid ? head_data : '0;
  assign rsp_fault   = rsp_valid && head_fault;
  assign pop         = rsp_valid && rsp_ready;
  assign s1_consumed = pop && fifo_empty;
  assign fifo_pop    = pop && !fifo_empty;
  assign fifo_push   = s1_valid_q && !s1_consumed && !fifo_full;

  // Program port write; honoured even while reset is asserted.
  always_ff @(posedge clk) begin
    if (prog_we && (32'(prog_addr) < 32'(DEPTH))) mem_q[prog_addr] <= prog_data;
  end

  // Stage 1 captures the read (old data on a same-edge program write) or the fault result.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_valid_q <= 1'b0;
      s1_fault_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_fault_q <= req_fault;
        s1_data_q  <= req_fault ? '0 : mem_q[rd_idx];
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (fifo_push),
    .push_data ({s1_fault_q, s1_data_q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_inst_fetch_mem.sv
// tb/tb_inst_fetch_mem.sv - self-checking bench for inst_fetch_mem
module tb_inst_fetch_mem;
  import inst_mem_pkg::*;

  localparam int DEPTH_P = 4096;
  localparam int RSP_D   = 4;

  logic        clk, reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, flush, prog_we;
  logic [31:0] req_addr, rsp_data, prog_data;
  logic [11:0] prog_addr;

  int errors = 0;
  int checks = 0;
  bit model_on = 0;

  logic [31:0] mem_m [DEPTH_P];
  rsp_entry_t  q [$];
  logic [31:0] image [8] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193,
                             32'h00418213, 32'h00528293, 32'h00630313, 32'h00738393};

  inst_fetch_mem #(
    .DATA_W    (32),
    .DEPTH     (DEPTH_P),
    .ADDR_W    (32),
    .RSP_DEPTH (RSP_D),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outstanding responses form one ordered queue, visible one edge after acceptance.
  always @(posedge clk) begin
    int unsigned sz;
    rsp_entry_t  e;
    sz = q.size();
    if (reset || flush) begin
      q.delete();
    end else begin
      if (sz != 0 && rsp_ready) void'(q.pop_front());
      if (req_valid && sz < RSP_D) begin
        e.fault = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH_P);
        e.data  = e.fault ? 32'h0 : mem_m[req_addr / 4];
        q.push_back(e);
      end
    end
    if (prog_we && prog_addr < DEPTH_P) mem_m[prog_addr] = prog_data;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      chk("m_rsp_valid", {31'b0, rsp_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("m_rsp_data", rsp_data, q[0].data);
        chk("m_rsp_fault", {31'b0, rsp_fault}, {31'b0, q[0].fault});
      end
      chk("m_req_ready", {31'b0, req_ready}, {31'b0, !reset && !flush && (q.size() < RSP_D)});
    end
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // Reset with image load through the program port
    tick();
    model_on = 1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      prog_we = 1'b1; prog_addr = 12'(i); prog_data = image[i];
      tick();
    end
    prog_we = 1'b0; reset = 1'b0;
    tick();
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Full-rate stream
    rsp_ready = 1'b1; req_valid = 1'b1;
    req_addr = 32'h0; tick(); chk("stream_w0", rsp_data, 32'h00000013);
    chk("stream_valid0", {31'b0, rsp_valid}, 32'd1);
    req_addr = 32'h4; tick(); chk("stream_w1", rsp_data, 32'h00100093);
    req_addr = 32'h8; tick(); chk("stream_w2", rsp_data, 32'h00200113);
    chk("stream_fault", {31'b0, rsp_fault}, 32'd0);
    req_valid = 1'b0; tick(); chk("stream_idle", {31'b0, rsp_valid}, 32'd0);

    // Backpressure: six requests offered, four accepted
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_addr = 32'(i * 4);
      tick();
      chk("bp_head_stable", rsp_data, 32'h00000013);
    end
    chk("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick(); chk("bp_pop1", rsp_data, 32'h00100093);
    chk("bp_req_ready_back", {31'b0, req_ready}, 32'd1);
    tick(); chk("bp_pop2", rsp_data, 32'h00200113);
    tick(); chk("bp_pop3", rsp_data, 32'h00308193);
    tick(); chk("bp_empty", {31'b0, rsp_valid}, 32'd0);

    // Faults: misaligned, out of range, then a normal fetch
    req_valid = 1'b1;
    req_addr = 32'h2; tick();
    chk("misalign_fault", {31'b0, rsp_fault}, 32'd1);
    chk("misalign_data", rsp_data, 32'd0);
    req_addr = 32'h4000; tick();
    chk("range_fault", {31'b0, rsp_fault}, 32'd1);
    req_addr = 32'h4; tick();
    chk("after_fault_data", rsp_data, 32'h00100093);
    chk("after_fault_flag", {31'b0, rsp_fault}, 32'd0);
    req_valid = 1'b0; tick();

    // Flush with three outstanding and a request in the flush cycle
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    flush = 1'b1; req_addr = 32'hC;
    #1 chk("flush_req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("flush_req_dropped", {31'b0, rsp_valid}, 32'd0);

    // Program port collision: same-edge read returns the old word
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h14;
    prog_we = 1'b1; prog_addr = 12'd5; prog_data = 32'hDEADBEEF;
    tick();
    prog_we = 1'b0;
    chk("collide_old", rsp_data, 32'h00528293);
    tick();
    chk("collide_new", rsp_data, 32'hDEADBEEF);
    req_valid = 1'b0; tick();

    // Reset mid-stream with two outstanding
    rsp_ready = 1'b0; req_valid = 1'b1;
    req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    reset = 1'b1; req_valid = 1'b0;
    #1 chk("midrst_ready_low", {31'b0, req_ready}, 32'd0);
    tick();
    chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_data", rsp_data, 32'd0);
    chk("midrst_fault", {31'b0, rsp_fault}, 32'd0);
    reset = 1'b0;
    tick();
    chk("midrst_ready_back", {31'b0, req_ready}, 32'd1);
    chk("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1; req_valid = 1'b1;
    req_addr = 32'h8;  tick(); chk("mem_kept_w2", rsp_data, 32'h00200113);
    req_addr = 32'h14; tick(); chk("mem_kept_w5", rsp_data, 32'hDEADBEEF);
    req_valid = 1'b0; tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
